// File: rtl/demux_router.sv
// 1-to-4 valid/ready demultiplexer with a one-word holding register per channel.
// Optional per-channel delivery counters are built when DEMUX_STATS_EN is defined.
module demux_router #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             address0,
  input  logic             address1,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3
`ifdef DEMUX_STATS_EN
  ,
  output logic [7:0]       stat0,
  output logic [7:0]       stat1,
  output logic [7:0]       stat2,
  output logic [7:0]       stat3
`endif
);

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  logic [3:0]            state_q, state_d;
  logic [3:0][WIDTH-1:0] buf_q, buf_d;
  logic [1:0]            sel;
  logic                  accept;
  logic [3:0]            drain;
  logic [3:0]            load;

  // A full channel can still take a word when its consumer drains it on the same edge.
  always_comb begin
    sel      = {address1, address0};
    in_ready = (state_q[sel] == EMPTY) | out_ready[sel];
    accept   = in_valid & in_ready;
    load     = 4'b0000;
    if (accept) load[sel] = 1'b1;
    drain    = 4'b0000;
    state_d  = state_q;
    buf_d    = buf_q;
    for (int i = 0; i < 4; i++) begin
      drain[i] = (state_q[i] == FULL) & out_ready[i];
      if (load[i]) begin
        state_d[i] = FULL;
        buf_d[i]   = in_data;
      end else if (drain[i]) begin
        state_d[i] = EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= {4{EMPTY}};
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  assign out_valid = state_q;
  assign out0      = buf_q[0];
  assign out1      = buf_q[1];
  assign out2      = buf_q[2];
  assign out3      = buf_q[3];

`ifdef DEMUX_STATS_EN
  logic [3:0][7:0] stat_q, stat_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    stat_d = stat_q;
    for (int i = 0; i < 4; i++) begin
      if (drain[i]) stat_d[i] = sat_inc(stat_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) stat_q <= '0;
    else       stat_q <= stat_d;
  end

  assign stat0 = stat_q[0];
  assign stat1 = stat_q[1];
  assign stat2 = stat_q[2];
  assign stat3 = stat_q[3];
`endif

endmodule
